// File: rtl/fifo_uart_tester.sv
// UART-commanded FIFO exerciser: writes INC/DEC bursts, reads words back to the UART,
// or verifies the FIFO contents against the last pattern and reports 'P'/'F'.
module fifo_uart_tester #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned BURST_LEN = 256,
  parameter int unsigned CNT_BITS  = 16
) (
  input  logic                 clk_in,
  input  logic                 n_rst,
  input  logic                 uart_rx_valid_in,
  input  logic [7:0]           uart_rx_data_in,
  input  logic                 uart_tx_ready_in,
  input  logic                 fifo_full_in,
  input  logic                 fifo_empty_in,
  input  logic [DATA_BITS-1:0] fifo_rd_data_in,
  output logic                 fifo_wr_en,
  output logic [DATA_BITS-1:0] fifo_wr_data_out,
  output logic                 fifo_rd_en,
  output logic                 uart_tx_en,
  output logic [DATA_BITS-1:0] uart_tx_data_out,
  output logic                 busy_out,
  output logic [CNT_BITS-1:0]  err_count_out
);

  typedef enum logic [2:0] {StIdle, StWrite, StRdReq, StRdTake, StReport} state_e;

  localparam logic [CNT_BITS-1:0]  LastCnt = CNT_BITS'(BURST_LEN - 1);
  localparam logic [DATA_BITS-1:0] ByteP   = DATA_BITS'(8'h50);
  localparam logic [DATA_BITS-1:0] ByteF   = DATA_BITS'(8'h46);
  localparam logic                 PatInc  = 1'b0;
  localparam logic                 PatDec  = 1'b1;
  localparam logic                 ModeRd  = 1'b0;
  localparam logic                 ModeVfy = 1'b1;

  state_e               r_state, w_state_d;
  logic                 r_pattern, w_pattern_d;
  logic                 r_mode, w_mode_d;
  logic                 r_cap_vld, w_cap_vld_d;
  logic [CNT_BITS-1:0]  r_cnt, w_cnt_d;
  logic [CNT_BITS-1:0]  r_exp, w_exp_d;
  logic [CNT_BITS-1:0]  r_err, w_err_d;
  logic [DATA_BITS-1:0] r_cap, w_cap_d;
  logic [DATA_BITS-1:0] r_tx_data, w_tx_data_d;

  function automatic logic [DATA_BITS-1:0] pattern_of(input logic dec,
                                                      input logic [CNT_BITS-1:0] v);
    logic [DATA_BITS-1:0] t;
    t = DATA_BITS'(v);
    return dec ? ~t : t;
  endfunction

  assign fifo_wr_data_out = pattern_of(r_pattern, r_cnt);
  assign uart_tx_data_out = r_tx_data;
  assign err_count_out    = r_err;
  assign busy_out         = (r_state != StIdle);

  always_comb begin
    w_state_d   = r_state;
    w_pattern_d = r_pattern;
    w_mode_d    = r_mode;
    w_cap_vld_d = r_cap_vld;
    w_cnt_d     = r_cnt;
    w_exp_d     = r_exp;
    w_err_d     = r_err;
    w_cap_d     = r_cap;
    w_tx_data_d = r_tx_data;
    fifo_wr_en  = 1'b0;
    fifo_rd_en  = 1'b0;
    uart_tx_en  = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (uart_rx_valid_in) begin
          case (uart_rx_data_in)
            8'h77: begin  // 'w'
              w_pattern_d = PatInc;
              w_cnt_d     = '0;
              w_state_d   = StWrite;
            end
            8'h64: begin  // 'd'
              w_pattern_d = PatDec;
              w_cnt_d     = '0;
              w_state_d   = StWrite;
            end
            8'h72: begin  // 'r'
              w_mode_d  = ModeRd;
              w_state_d = StRdReq;
            end
            8'h76: begin  // 'v'
              w_mode_d  = ModeVfy;
              w_exp_d   = '0;
              w_err_d   = '0;
              w_state_d = StRdReq;
            end
            default: ;
          endcase
        end
      end

      StWrite: begin
        if (!fifo_full_in) begin
          fifo_wr_en = 1'b1;
          w_cnt_d    = r_cnt + 1'b1;
          if (r_cnt == LastCnt) w_state_d = StIdle;
        end
      end

      StRdReq: begin
        if (!fifo_empty_in) begin
          fifo_rd_en  = 1'b1;
          w_cap_vld_d = 1'b0;
          w_state_d   = StRdTake;
        end else if (r_mode == ModeVfy) begin
          w_tx_data_d = (r_err == '0) ? ByteP : ByteF;
          w_state_d   = StReport;
        end else begin
          w_state_d = StIdle;
        end
      end

      StRdTake: begin
        // First cycle only captures the read word; it is acted on the cycle after.
        if (!r_cap_vld) begin
          w_cap_d     = fifo_rd_data_in;
          w_cap_vld_d = 1'b1;
          if (r_mode == ModeRd) w_tx_data_d = fifo_rd_data_in;
        end else if (r_mode == ModeRd) begin
          if (uart_tx_ready_in) begin
            uart_tx_en = 1'b1;
            w_state_d  = StRdReq;
          end
        end else begin
          if ((r_cap != pattern_of(r_pattern, r_exp)) && (r_err != '1)) begin
            w_err_d = r_err + 1'b1;
          end
          w_exp_d   = r_exp + 1'b1;
          w_state_d = StRdReq;
        end
      end

      StReport: begin
        if (uart_tx_ready_in) begin
          uart_tx_en = 1'b1;
          w_state_d  = StIdle;
        end
      end

      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= StIdle;
      r_pattern <= PatInc;
      r_mode    <= ModeRd;
      r_cap_vld <= 1'b0;
      r_cnt     <= '0;
      r_exp     <= '0;
      r_err     <= '0;
      r_cap     <= '0;
      r_tx_data <= '0;
    end else begin
      r_state   <= w_state_d;
      r_pattern <= w_pattern_d;
      r_mode    <= w_mode_d;
      r_cap_vld <= w_cap_vld_d;
      r_cnt     <= w_cnt_d;
      r_exp     <= w_exp_d;
      r_err     <= w_err_d;
      r_cap     <= w_cap_d;
      r_tx_data <= w_tx_data_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tester.sv
// Directed bench for fifo_uart_tester: behavioural FIFO model plus write/transmit scoreboards.
module tb_fifo_uart_tester;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk_in = 1'b0;
  logic          n_rst = 1'b0;
  logic          uart_rx_valid_in = 1'b0;
  logic [7:0]    uart_rx_data_in = 8'h00;
  logic          uart_tx_ready_in = 1'b0;
  logic          fifo_full_in = 1'b0;
  logic          fifo_empty_in;
  logic [DW-1:0] fifo_rd_data_in;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data_out;
  logic          fifo_rd_en;
  logic          uart_tx_en;
  logic [DW-1:0] uart_tx_data_out;
  logic          busy_out;
  logic [CW-1:0] err_count_out;

  fifo_uart_tester #(
    .DATA_BITS(DW),
    .BURST_LEN(4),
    .CNT_BITS (CW)
  ) dut (
    .clk_in          (clk_in),
    .n_rst           (n_rst),
    .uart_rx_valid_in(uart_rx_valid_in),
    .uart_rx_data_in (uart_rx_data_in),
    .uart_tx_ready_in(uart_tx_ready_in),
    .fifo_full_in    (fifo_full_in),
    .fifo_empty_in   (fifo_empty_in),
    .fifo_rd_data_in (fifo_rd_data_in),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_wr_data_out(fifo_wr_data_out),
    .fifo_rd_en      (fifo_rd_en),
    .uart_tx_en      (uart_tx_en),
    .uart_tx_data_out(uart_tx_data_out),
    .busy_out        (busy_out),
    .err_count_out   (err_count_out)
  );

  always #5 clk_in = ~clk_in;

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: read data appears one cycle after fifo_rd_en.
  logic [DW-1:0] mem [64];
  logic [5:0]    wp = '0, rp = '0;
  logic [DW-1:0] rd_q = '0;
  logic          model_clr = 1'b0, model_cap = 1'b0, ld_en = 1'b0;
  logic [DW-1:0] ld_data = '0;

  assign fifo_empty_in   = (wp == rp);
  assign fifo_rd_data_in = rd_q;

  always @(posedge clk_in) begin
    if (model_clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (ld_en || (model_cap && fifo_wr_en)) begin
        mem[wp] <= ld_en ? ld_data : fifo_wr_data_out;
        wp      <= wp + 1'b1;
      end
      if (fifo_rd_en) begin
        rd_q <= mem[rp];
        rp   <= rp + 1'b1;
      end
    end
  end

  // Scoreboards and strobe monitor.
  logic [DW-1:0] exp_wr_q[$];
  logic [DW-1:0] exp_tx_q[$];
  int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0;
  logic prev_tx = 1'b0;

  always @(negedge clk_in) begin
    if (n_rst) begin
      if (fifo_wr_en) begin
        wr_cnt++;
        chk("wr_while_full", fifo_full_in, 0);
        chk("wr_expected", exp_wr_q.size() != 0, 1);
        if (exp_wr_q.size() != 0) chk("wr_data", fifo_wr_data_out, exp_wr_q.pop_front());
      end
      if (fifo_rd_en) begin
        rd_cnt++;
        chk("rd_while_empty", fifo_empty_in, 0);
      end
      if (uart_tx_en) begin
        tx_cnt++;
        chk("tx_width", prev_tx, 0);
        chk("tx_expected", exp_tx_q.size() != 0, 1);
        if (exp_tx_q.size() != 0) chk("tx_data", uart_tx_data_out, exp_tx_q.pop_front());
      end
      prev_tx = uart_tx_en;
    end else begin
      prev_tx = 1'b0;
    end
  end

  task automatic send(input logic [7:0] b);
    uart_rx_valid_in = 1'b1;
    uart_rx_data_in  = b;
    @(posedge clk_in); #1;
    uart_rx_valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk_in);
    while (busy_out && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    chk(tag, busy_out, 0);
    @(posedge clk_in); #1;
  endtask

  task automatic clear_model();
    model_clr = 1'b1;
    @(posedge clk_in); #1;
    model_clr = 1'b0;
  endtask

  task automatic preload(input logic [DW-1:0] d);
    ld_en   = 1'b1;
    ld_data = d;
    @(posedge clk_in); #1;
    ld_en   = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"}, fifo_wr_en, 0);
    chk({tag, "_rd_en"}, fifo_rd_en, 0);
    chk({tag, "_tx_en"}, uart_tx_en, 0);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_err"}, err_count_out, 0);
    chk({tag, "_tx_data"}, uart_tx_data_out, 0);
    chk({tag, "_wr_data"}, fifo_wr_data_out, 0);
  endtask

  int snap;

  initial begin
    // Reset state
    #3;
    chk_all_zero("reset");
    @(posedge clk_in); #1;
    n_rst = 1'b1;
    @(posedge clk_in); #1;

    // INC burst of 4, never full: four consecutive writes 0..3, idle right after
    model_cap = 1'b1;
    for (int i = 0; i < 4; i++) exp_wr_q.push_back(DW'(i));
    snap = wr_cnt;
    send("w");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      chk("burst_consecutive_wr", fifo_wr_en, 1);
    end
    @(negedge clk_in);
    chk("burst_busy_drop", busy_out, 0);
    chk("burst_no_extra_wr", fifo_wr_en, 0);
    @(posedge clk_in); #1;
    chk("burst_wr_total", wr_cnt - snap, 4);
    model_cap = 1'b0;

    // Verify the INC data just stored: no errors, report 'P'
    uart_tx_ready_in = 1'b1;
    exp_tx_q.push_back(8'h50);
    snap = rd_cnt;
    send("v");
    wait_idle("vfy_pass_idle");
    chk("vfy_pass_err", err_count_out, 0);
    chk("vfy_pass_reads", rd_cnt - snap, 4);
    chk("vfy_pass_tx_drained", exp_tx_q.size(), 0);

    // Stall: full high for burst cycles 2-3, data resumes at stalled value
    clear_model();
    for (int i = 0; i < 4; i++) exp_wr_q.push_back(DW'(i));
    snap = wr_cnt;
    send("w");
    @(posedge clk_in); #1;
    fifo_full_in = 1'b1;
    @(negedge clk_in);
    chk("stall_c2_no_wr", fifo_wr_en, 0);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    chk("stall_c3_no_wr", fifo_wr_en, 0);
    chk("stall_busy", busy_out, 1);
    @(posedge clk_in); #1;
    fifo_full_in = 1'b0;
    wait_idle("stall_idle");
    chk("stall_wr_total", wr_cnt - snap, 4);
    chk("stall_wr_drained", exp_wr_q.size(), 0);

    // Read mode: FIFO holds A5,3C; TX not ready for 5 cycles
    clear_model();
    preload(8'hA5);
    preload(8'h3C);
    uart_tx_ready_in = 1'b0;
    exp_tx_q.push_back(8'hA5);
    exp_tx_q.push_back(8'h3C);
    snap = tx_cnt;
    send("r");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      chk("read_hold_no_tx", uart_tx_en, 0);
      @(posedge clk_in); #1;
    end
    uart_tx_ready_in = 1'b1;
    wait_idle("read_idle");
    chk("read_tx_total", tx_cnt - snap, 2);
    chk("read_tx_drained", exp_tx_q.size(), 0);

    // DEC burst FF,FE,FD,FC then verify against FF,00,FD: one mismatch, report 'F'
    for (int i = 0; i < 4; i++) exp_wr_q.push_back(8'hFF - DW'(i));
    send("d");
    wait_idle("dec_idle");
    chk("dec_wr_drained", exp_wr_q.size(), 0);
    clear_model();
    preload(8'hFF);
    preload(8'h00);
    preload(8'hFD);
    exp_tx_q.push_back(8'h46);
    send("v");
    wait_idle("vfy_fail_idle");
    chk("vfy_fail_err", err_count_out, 1);
    chk("vfy_fail_tx_drained", exp_tx_q.size(), 0);

    // Verify on empty FIFO: no reads, err cleared, report 'P'
    exp_tx_q.push_back(8'h50);
    snap = rd_cnt;
    send("v");
    wait_idle("vfy_empty_idle");
    chk("vfy_empty_reads", rd_cnt - snap, 0);
    chk("vfy_empty_err", err_count_out, 0);
    chk("vfy_empty_tx_drained", exp_tx_q.size(), 0);

    // Reset mid-burst, then restart; a 'w' while busy is ignored
    exp_wr_q.push_back(8'h00);
    exp_wr_q.push_back(8'h01);
    send("w");
    @(negedge clk_in);
    @(negedge clk_in);
    #2;
    n_rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk_in); #1;
    n_rst = 1'b1;
    @(negedge clk_in);
    chk("post_rst_idle", busy_out, 0);
    chk("post_rst_no_wr", fifo_wr_en, 0);
    chk("midrst_wr_drained", exp_wr_q.size(), 0);
    @(posedge clk_in); #1;
    for (int i = 0; i < 4; i++) exp_wr_q.push_back(DW'(i));
    snap = wr_cnt;
    send("w");
    send("w");
    wait_idle("restart_idle");
    repeat (3) @(posedge clk_in);
    #1;
    chk("restart_wr_total", wr_cnt - snap, 4);
    chk("restart_wr_drained", exp_wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
